scalar_mem_ctrl: RTL and testbench
==================================

SCALAR_MEM_CTRL -- requirements
Module: scalar_mem_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the width of the scalar word.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, the width of the pending-store counter and ctrl_count.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset; synchronous, active-low.
REQ-005 The module SHALL have ports ld_req_valid (input, 1) and ld_req_ready (output, 1), the elastic load-request handshake, carrying no address.
REQ-006 The module SHALL have ports ld_data (output, DATA_WIDTH), ld_data_valid (output, 1) and ld_data_ready (input, 1), the load result channel.
REQ-007 The module SHALL have ports st_valid (input, 1), st_ready (output, 1) and st_data (input, DATA_WIDTH), the store channel.
REQ-008 The module SHALL have ports ctrl_valid (input, 1), ctrl_ready (output, 1) and ctrl_count (input, CNT_WIDTH), the number of stores announced by a basic block.
REQ-009 The module SHALL have ports end_valid (input, 1) and end_ready (output, 1), the end-of-kernel token.
REQ-010 The module SHALL have ports ce0 (output, 1), we0 (output, 1), mem_din0 (output, DATA_WIDTH) and mem_dout0 (input, DATA_WIDTH), the single-word memory port; read data appears one cycle after ce0=1 with we0=0.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse to the memory model.

Function
REQ-012 The block SHALL use FSM states IDLE, RD_ISSUED, RD_HOLD and FINISH.
REQ-013 In IDLE, st_ready SHALL be 1; a store handshake SHALL drive ce0=1, we0=1 and mem_din0=st_data combinationally in the same cycle, with the state remaining IDLE.
REQ-014 In IDLE, ld_req_ready SHALL equal !st_valid, giving stores priority over loads when both are valid in the same cycle.
REQ-015 A load handshake SHALL drive ce0=1 and we0=0 in that cycle (N) and move the FSM to RD_ISSUED.
REQ-016 In RD_ISSUED, the block SHALL register mem_dout0 into ld_data and move to RD_HOLD; ld_data_valid SHALL be 1 only in RD_HOLD, first in cycle N+2.
REQ-017 In RD_HOLD, ld_data SHALL stay stable until ld_data_ready=1, then the FSM SHALL return to IDLE; at most one load is outstanding at any time.
REQ-018 In all states other than IDLE, st_ready, ld_req_ready and end_ready SHALL be 0.
REQ-019 ctrl_ready SHALL be 1 in every state except FINISH.
REQ-020 On a ctrl handshake the pending counter SHALL add ctrl_count; on a store handshake it SHALL subtract 1; a simultaneous ctrl handshake and store SHALL apply the net value in one cycle.
REQ-021 The pending counter SHALL saturate at 0 (an extra store is still performed) and at 2^CNT_WIDTH-1.
REQ-022 end_ready SHALL be 1 only when state=IDLE, pending=0, and st_valid, ld_req_valid and ctrl_valid are all 0.
REQ-023 An end handshake SHALL move the FSM to FINISH.
REQ-024 In FINISH, done SHALL be 1 (registered) for exactly one cycle, then the FSM SHALL return to IDLE with the counter at 0, ready for the next transaction.
REQ-025 Outside FINISH, done SHALL be 0.
REQ-026 Outside a store or load-issue cycle, ce0 and we0 SHALL be 0.

Reset
REQ-027 While rst=0 at a clock edge: FSM=IDLE, pending=0, ld_data=0, done=0.
REQ-028 While rst=0, ce0, we0, ld_data_valid and all ready outputs SHALL be forced to 0.
REQ-029 A reset arriving in RD_ISSUED or RD_HOLD SHALL discard the load with no ld_data_valid pulse; a reset arriving in FINISH SHALL suppress the remaining done.

Structure
REQ-030 The FSM state encoding SHALL live in a shared package, scalar_mem_pkg; DATA_WIDTH and CNT_WIDTH defaults SHALL live there too.
REQ-031 The pending counter SHALL be a sub-module, store_pending_cnt (add, decrement, saturate, zero flag); all else SHALL stay flat.

Verification
REQ-032 st_valid=1, st_data=0x0000_00A5 in IDLE -> same cycle ce0=1, we0=1, mem_din0=0xA5; a load next -> ld_data=0xA5 with ld_data_valid first at N+2.
REQ-033 st_valid and ld_req_valid both 1 in the same cycle -> store accepted, ld_req_ready=0; the load is accepted the following cycle.
REQ-034 ld_data_ready held 0 for 5 cycles in RD_HOLD -> ld_data stable and valid throughout; ld_req_ready=0 until release.
REQ-035 ctrl_count=3, then end_valid=1, then 3 stores -> end_ready=0 until the third store; handshake next cycle; done=1 exactly one cycle later.
REQ-036 ctrl handshake (count=2) in the same cycle as a store with pending=1 -> pending=2 next cycle.
REQ-037 rst=0 asserted in RD_HOLD -> next cycle ld_data_valid=0, ld_data=0, state IDLE; no done pulse.

Source files
------------

// File: rtl/scalar_mem_pkg.sv
// Shared definitions for the scalar memory controller: FSM encoding and default widths.
package scalar_mem_pkg;

    localparam int SCALAR_DATA_WIDTH = 32;
    localparam int SCALAR_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ISSUED = 2'd1,
        RD_HOLD   = 2'd2,
        FINISH    = 2'd3
    } state_t;

endpackage

// File: rtl/store_pending_cnt.sv
// Pending-store counter: adds announced store counts, retires one per store,
// saturates at both ends and reports when nothing is outstanding.
module store_pending_cnt
    import scalar_mem_pkg::*;
#(
    parameter int CNT_WIDTH = SCALAR_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_add_en,
    input  logic [CNT_WIDTH-1:0] i_add_val,
    input  logic                 i_dec_en,
    input  logic                 i_clr,
    output logic                 o_zero
);

    localparam logic [CNT_WIDTH:0] MAX_EXT = {1'b0, {CNT_WIDTH{1'b1}}};

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH:0]   w_sum;
    logic [CNT_WIDTH:0]   w_net;
    logic [CNT_WIDTH-1:0] w_next;

    // Net add/decrement in one extra bit so both saturation points are visible.
    always_comb begin
        w_sum  = {1'b0, r_count};
        w_net  = {1'b0, r_count};
        w_next = r_count;
        if (i_add_en) begin
            w_sum = {1'b0, r_count} + {1'b0, i_add_val};
        end else begin
            w_sum = {1'b0, r_count};
        end
        if (i_dec_en && (w_sum != {(CNT_WIDTH+1){1'b0}})) begin
            w_net = w_sum - {{CNT_WIDTH{1'b0}}, 1'b1};
        end else begin
            w_net = w_sum;
        end
        if (w_net > MAX_EXT) begin
            w_next = {CNT_WIDTH{1'b1}};
        end else begin
            w_next = w_net[CNT_WIDTH-1:0];
        end
    end

    // Counter register with synchronous active-low reset and end-of-kernel clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_count <= w_next;
        end
    end

    assign o_zero = (r_count == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/scalar_mem_ctrl.sv
// Single-word memory controller arbitrating stores and loads, tracking announced
// stores and signalling kernel completion once every announced store has landed.
module scalar_mem_ctrl
    import scalar_mem_pkg::*;
#(
    parameter int DATA_WIDTH = SCALAR_DATA_WIDTH,
    parameter int CNT_WIDTH  = SCALAR_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_data_valid,
    input  logic                  ld_data_ready,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic [CNT_WIDTH-1:0]  ctrl_count,
    input  logic                  end_valid,
    output logic                  end_ready,
    output logic                  ce0,
    output logic                  we0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    input  logic [DATA_WIDTH-1:0] mem_dout0,
    output logic                  done
);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_ld_data;
    logic                  r_done;
    logic                  w_idle;
    logic                  w_st_fire;
    logic                  w_ld_fire;
    logic                  w_ctrl_fire;
    logic                  w_end_fire;
    logic                  w_pend_zero;

    // Handshake decode; everything is held off while reset is low.
    always_comb begin
        w_idle        = rst && (r_state == IDLE);
        st_ready      = w_idle;
        ld_req_ready  = w_idle && !st_valid;
        ctrl_ready    = rst && (r_state != FINISH);
        end_ready     = w_idle && w_pend_zero && !st_valid && !ld_req_valid && !ctrl_valid;
        w_st_fire     = st_ready && st_valid;
        w_ld_fire     = ld_req_ready && ld_req_valid;
        w_ctrl_fire   = ctrl_ready && ctrl_valid;
        w_end_fire    = end_ready && end_valid;
        ld_data_valid = rst && (r_state == RD_HOLD);
        ce0           = w_st_fire || w_ld_fire;
        we0           = w_st_fire;
        if (w_st_fire) begin
            mem_din0 = st_data;
        end else begin
            mem_din0 = {DATA_WIDTH{1'b0}};
        end
    end

    assign ld_data = r_ld_data;
    assign done    = r_done && rst;

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_ld_fire) begin
                    w_next_state = RD_ISSUED;
                end else if (w_end_fire) begin
                    w_next_state = FINISH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD_ISSUED: w_next_state = RD_HOLD;
            RD_HOLD: begin
                if (ld_data_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RD_HOLD;
                end
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State, load-data capture and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ld_data <= {DATA_WIDTH{1'b0}};
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_end_fire;
            if (r_state == RD_ISSUED) begin
                r_ld_data <= mem_dout0;
            end else begin
                r_ld_data <= r_ld_data;
            end
        end
    end

    store_pending_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .i_add_en  (w_ctrl_fire),
        .i_add_val (ctrl_count),
        .i_dec_en  (w_st_fire),
        .i_clr     (rst && (r_state == FINISH)),
        .o_zero    (w_pend_zero)
    );

endmodule

// File: tb/tb_scalar_mem_ctrl.sv
// Self-checking bench for scalar_mem_ctrl: table vectors, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_scalar_mem_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req_valid, ld_req_ready, ld_data_valid, ld_data_ready;
    logic [DW-1:0] ld_data;
    logic          st_valid, st_ready;
    logic [DW-1:0] st_data;
    logic          ctrl_valid, ctrl_ready;
    logic [CW-1:0] ctrl_count;
    logic          end_valid, end_ready;
    logic          ce0, we0, done;
    logic [DW-1:0] mem_din0, mem_dout0;
    logic [DW-1:0] mem_q = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scalar_mem_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_data(ld_data), .ld_data_valid(ld_data_valid), .ld_data_ready(ld_data_ready),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_count(ctrl_count),
        .end_valid(end_valid), .end_ready(end_ready),
        .ce0(ce0), .we0(we0), .mem_din0(mem_din0), .mem_dout0(mem_dout0),
        .done(done)
    );

    // Single-word memory: write on ce0&we0, read data one cycle after ce0&!we0.
    initial mem_dout0 = 32'h0;
    always @(posedge clk) begin
        if (ce0 && we0) mem_q <= mem_din0;
        else if (ce0) mem_dout0 <= mem_q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req_valid = 1'b0; ld_data_ready = 1'b0; st_valid = 1'b0; st_data = 32'h0;
        ctrl_valid = 1'b0; ctrl_count = 4'h0; end_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rst_v, st_v, ld_v, ctrl_v, end_v;
        logic [31:0] data;
        logic        e_st, e_ld, e_ctrl, e_end, e_ce, e_we;
        logic [31:0] e_din;
    } vec_t;

    vec_t vecs[8];

    // Reference model state (transaction level)
    int          m_pend, m_phase;
    bit          m_fin;
    logic [31:0] m_word, m_ld;

    initial begin
        rst = 1'b0;
        idle_inputs();
        vecs[0] = '{1'b0,1'b1,1'b1,1'b1,1'b0,32'h11,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,    1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0};
        vecs[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h5A,   1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,32'h5A};
        vecs[3] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,    1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,32'h0};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h33,   1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,32'h33};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,    1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,32'h0,    1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0};
        vecs[7] = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h0,    1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,32'h0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            rst = vecs[i].rst_v; st_valid = vecs[i].st_v; ld_req_valid = vecs[i].ld_v;
            ctrl_valid = vecs[i].ctrl_v; ctrl_count = 4'h2; end_valid = vecs[i].end_v;
            st_data = vecs[i].data;
            #2;
            chk($sformatf("vec%0d_st_ready", i), st_ready, vecs[i].e_st);
            chk($sformatf("vec%0d_ld_req_ready", i), ld_req_ready, vecs[i].e_ld);
            chk($sformatf("vec%0d_ctrl_ready", i), ctrl_ready, vecs[i].e_ctrl);
            chk($sformatf("vec%0d_end_ready", i), end_ready, vecs[i].e_end);
            chk($sformatf("vec%0d_ce0", i), ce0, vecs[i].e_ce);
            chk($sformatf("vec%0d_we0", i), we0, vecs[i].e_we);
            chk($sformatf("vec%0d_mem_din0", i), mem_din0, vecs[i].e_din);
            idle_inputs();
            rst = 1'b1;
        end

        // Store then load: data back with valid first at N+2, then hold for 5 cycles
        do_reset();
        chk("rst_done", done, 1'b0);
        chk("rst_ld_data", ld_data, 32'h0);
        st_valid = 1'b1; st_data = 32'h0000_00A5;
        #2;
        chk("st_ce0", ce0, 1'b1); chk("st_we0", we0, 1'b1); chk("st_din", mem_din0, 32'hA5);
        step();
        st_valid = 1'b0; ld_req_valid = 1'b1;
        #2;
        chk("ld_req_ready", ld_req_ready, 1'b1); chk("ld_ce0", ce0, 1'b1); chk("ld_we0", we0, 1'b0);
        step();
        ld_req_valid = 1'b0;
        #2;
        chk("n1_valid", ld_data_valid, 1'b0); chk("n1_ld_req_ready", ld_req_ready, 1'b0);
        chk("n1_st_ready", st_ready, 1'b0);
        step();
        ld_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("hold%0d_valid", i), ld_data_valid, 1'b1);
            chk($sformatf("hold%0d_data", i), ld_data, 32'hA5);
            chk($sformatf("hold%0d_ld_req_ready", i), ld_req_ready, 1'b0);
            chk($sformatf("hold%0d_ce0", i), ce0, 1'b0);
            step();
        end
        ld_data_ready = 1'b1;
        ld_req_valid = 1'b0;
        step();
        ld_data_ready = 1'b0;
        #2;
        chk("release_st_ready", st_ready, 1'b1); chk("release_valid", ld_data_valid, 1'b0);

        // Store and load together: store wins, load accepted next cycle
        st_valid = 1'b1; ld_req_valid = 1'b1; st_data = 32'h1234_5678;
        #2;
        chk("both_st_ready", st_ready, 1'b1); chk("both_ld_req_ready", ld_req_ready, 1'b0);
        chk("both_we0", we0, 1'b1);
        step();
        st_valid = 1'b0;
        #2;
        chk("next_ld_req_ready", ld_req_ready, 1'b1); chk("next_ce0", ce0, 1'b1);
        chk("next_we0", we0, 1'b0);
        step();
        ld_req_valid = 1'b0; ld_data_ready = 1'b1;
        step();
        #2;
        chk("both_ld_valid", ld_data_valid, 1'b1); chk("both_ld_data", ld_data, 32'h1234_5678);
        step();
        ld_data_ready = 1'b0;

        // ctrl=3, end waiting, three stores, then end handshake and done pulse
        do_reset();
        ctrl_valid = 1'b1; ctrl_count = 4'd3;
        #2;
        chk("ctrl_ready", ctrl_ready, 1'b1);
        step();
        ctrl_valid = 1'b0; end_valid = 1'b1;
        #2;
        chk("end_wait", end_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_data = 32'(i);
            #2;
            chk($sformatf("end_wait_st%0d", i), end_ready, 1'b0);
            step();
        end
        st_valid = 1'b0;
        #2;
        chk("end_ready_after3", end_ready, 1'b1);
        chk("done_before", done, 1'b0);
        step();
        end_valid = 1'b0;
        #2;
        chk("done_pulse", done, 1'b1); chk("finish_ctrl_ready", ctrl_ready, 1'b0);
        chk("finish_st_ready", st_ready, 1'b0);
        step();
        #2;
        chk("done_gone", done, 1'b0); chk("post_st_ready", st_ready, 1'b1);
        chk("post_end_ready", end_ready, 1'b1);

        // ctrl(2) with a simultaneous store while pending=1 leaves pending=2
        ctrl_valid = 1'b1; ctrl_count = 4'd1;
        step();
        ctrl_count = 4'd2; st_valid = 1'b1; st_data = 32'hCAFE_0077;
        #2;
        chk("net_st_ready", st_ready, 1'b1); chk("net_ctrl_ready", ctrl_ready, 1'b1);
        step();
        idle_inputs();
        #2;
        chk("net_pend2", end_ready, 1'b0);
        st_valid = 1'b1; st_data = 32'hCAFE_0077;
        step();
        st_valid = 1'b0;
        #2;
        chk("net_pend1", end_ready, 1'b0);
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
        #2;
        chk("net_pend0", end_ready, 1'b1);

        // Reset in RD_HOLD discards the load
        ld_req_valid = 1'b1;
        step();
        ld_req_valid = 1'b0;
        step();
        #2;
        chk("rh_valid", ld_data_valid, 1'b1); chk("rh_data", ld_data, 32'hCAFE_0077);
        rst = 1'b0;
        #2;
        chk("rh_rst_valid", ld_data_valid, 1'b0); chk("rh_rst_ctrl_ready", ctrl_ready, 1'b0);
        chk("rh_rst_st_ready", st_ready, 1'b0);
        step();
        rst = 1'b1;
        #2;
        chk("rh_after_valid", ld_data_valid, 1'b0); chk("rh_after_data", ld_data, 32'h0);
        chk("rh_after_idle", st_ready, 1'b1); chk("rh_after_done", done, 1'b0);
        step();
        #2;
        chk("rh_later_valid", ld_data_valid, 1'b0);

        // Reset during FINISH suppresses done
        end_valid = 1'b1;
        step();
        end_valid = 1'b0; rst = 1'b0;
        #2;
        chk("fin_rst_done", done, 1'b0);
        step();
        rst = 1'b1;
        #2;
        chk("fin_rst_after_done", done, 1'b0); chk("fin_rst_idle", st_ready, 1'b1);

        // Upper saturation: 15+15 clamps at 15, so 14 stores leave one pending
        ctrl_valid = 1'b1; ctrl_count = 4'hF;
        step(); step();
        ctrl_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            st_valid = 1'b1; step();
        end
        st_valid = 1'b0;
        #2;
        chk("sat_pend1", end_ready, 1'b0);
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
        #2;
        chk("sat_pend0", end_ready, 1'b1);
        st_valid = 1'b1;
        #2;
        chk("extra_store_ce0", ce0, 1'b1);
        step();
        st_valid = 1'b0;
        #2;
        chk("extra_store_floor", end_ready, 1'b1);

        // Randomized run against the reference model
        do_reset();
        st_valid = 1'b1; st_data = 32'hDEAD_BEEF;
        step();
        st_valid = 1'b0;
        m_pend = 0; m_phase = 0; m_fin = 1'b0; m_word = 32'hDEAD_BEEF; m_ld = 32'h0;
        for (int c = 0; c < 1500; c++) begin
            bit e_idle, e_st, e_ld, e_ctrl, e_end, st_f, ld_f, ctrl_f, end_f;
            int np;
            st_valid      = ($urandom_range(0, 9) < 3);
            ld_req_valid  = ($urandom_range(0, 9) < 2);
            ctrl_valid    = ($urandom_range(0, 9) < 2);
            ctrl_count    = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            end_valid     = ($urandom_range(0, 9) < 3);
            ld_data_ready = 1'($urandom_range(0, 1));
            st_data       = $urandom;
            #2;
            e_idle = (m_phase == 0) && !m_fin;
            e_st   = e_idle;
            e_ld   = e_idle && !st_valid;
            e_ctrl = !m_fin;
            e_end  = e_idle && (m_pend == 0) && !st_valid && !ld_req_valid && !ctrl_valid;
            st_f   = e_st && st_valid;
            ld_f   = e_ld && ld_req_valid;
            ctrl_f = e_ctrl && ctrl_valid;
            end_f  = e_end && end_valid;
            chk("rnd_st_ready", st_ready, e_st);
            chk("rnd_ld_req_ready", ld_req_ready, e_ld);
            chk("rnd_ctrl_ready", ctrl_ready, e_ctrl);
            chk("rnd_end_ready", end_ready, e_end);
            chk("rnd_ce0", ce0, st_f || ld_f);
            chk("rnd_we0", we0, st_f);
            chk("rnd_ld_data_valid", ld_data_valid, m_phase == 2);
            chk("rnd_done", done, m_fin);
            if (m_phase == 2) chk("rnd_ld_data", ld_data, m_ld);
            if (st_f) chk("rnd_mem_din0", mem_din0, st_data);
            if (m_fin) begin
                m_fin = 1'b0; m_pend = 0;
            end
            np = m_pend + (ctrl_f ? int'(ctrl_count) : 0) - (st_f ? 1 : 0);
            m_pend = (np < 0) ? 0 : ((np > PMAX) ? PMAX : np);
            if (m_phase == 2) begin
                if (ld_data_ready) m_phase = 0;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (ld_f) begin
                m_phase = 1; m_ld = m_word;
            end
            if (st_f) m_word = st_data;
            if (end_f) m_fin = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
